// File: rtl/moka_rv32i_dmem_responder_if.sv
// Load/store bus between the RV32I Memory stage and its data-memory responder.
//   master : core side   - drives req, we, addr, wdata, size, load_unsigned;
//                          receives rdata, ready, err, busy
//   slave  : memory side - the mirror image
interface moka_rv32i_dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            size;
    logic                  load_unsigned;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  err;
    logic                  busy;

    modport master (
        output req, we, addr, wdata, size, load_unsigned,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, size, load_unsigned,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/moka_rv32i_dmem_responder.sv
// Data-memory responder for the pipelined RV32I core (Memory stage side).
// Accepts one load/store at a time, waits WAIT_STATES cycles, then completes
// with a one-cycle ready pulse. Loads return sign/zero-extended data; stores
// write only the byte lanes selected by size/addr. Misaligned or illegal
// accesses complete with err, rdata = 0 and no memory write.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport of moka_rv32i_dmem_responder_if
//            (req/we/addr/wdata/size/load_unsigned in, rdata/ready/err/busy out)
//   rd_count, wr_count, err_count - access statistics, present only when
//            MOKA_RV32I_DMEM_STATS_EN is defined
//
// State | meaning
// IDLE  | waiting for req; request accepted here
// WAIT  | counting down wait states, inputs ignored
// RESP  | ready (and err) high for one cycle, then back to IDLE
module moka_rv32i_dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    moka_rv32i_dmem_responder_if.slave bus
`ifdef MOKA_RV32I_DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [15:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [1:0]            lat_size;
    logic                  lat_lu;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // With zero wait states the response is produced on the acceptance edge,
    // so the access is decoded from the live inputs while in IDLE.
    logic                  cur_we;
    logic [DATA_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [1:0]            cur_size;
    logic                  cur_lu;

    logic                  do_resp;
    logic                  do_write;
    logic                  bad;
    logic [AW-1:0]         idx;
    logic [DATA_WIDTH-1:0] mem_word;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wlane;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  unused_addr_bits;

    assign cur_we    = (state == S_IDLE) ? bus.we            : lat_we;
    assign cur_addr  = (state == S_IDLE) ? bus.addr          : lat_addr;
    assign cur_wdata = (state == S_IDLE) ? bus.wdata         : lat_wdata;
    assign cur_size  = (state == S_IDLE) ? bus.size          : lat_size;
    assign cur_lu    = (state == S_IDLE) ? bus.load_unsigned : lat_lu;

    assign do_resp  = ((state == S_IDLE) && bus.req && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));
    assign do_write = do_resp && cur_we && !bad && rst_n;

    // Upper address bits wrap the address space modulo the memory size.
    assign idx              = cur_addr[AW+1:2];
    assign unused_addr_bits = ^cur_addr[DATA_WIDTH-1:AW+2];
    assign mem_word         = mem[idx];

    always_comb begin
        bad   = 1'b0;
        be    = 4'b0000;
        wlane = cur_wdata;
        case (cur_size)
            2'd0: begin
                be[cur_addr[1:0]] = 1'b1;
                wlane             = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                bad   = cur_addr[0];
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{cur_wdata[15:0]}};
            end
            2'd2: begin
                bad = |cur_addr[1:0];
                be  = 4'b1111;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        byte_sel = mem_word[7:0];
        case (cur_addr[1:0])
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];
        case (cur_size)
            2'd0:    load_val = cur_lu ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    load_val = cur_lu ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_word;
        endcase
    end

    // Memory array carries no reset; writes happen on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= 2'd0;
            lat_lu    <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MOKA_RV32I_DMEM_STATS_EN
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
            err_count <= 16'd0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (do_resp) begin
                ready_q <= 1'b1;
                err_q   <= bad;
                if (bad) begin
                    rdata_q <= '0;
                end else if (!cur_we) begin
                    rdata_q <= load_val;
                end
`ifdef MOKA_RV32I_DMEM_STATS_EN
                if (bad) begin
                    err_count <= err_count + 16'd1;
                end else if (cur_we) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
`endif
            end
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_addr  <= bus.addr;
                        lat_wdata <= bus.wdata;
                        lat_size  <= bus.size;
                        lat_lu    <= bus.load_unsigned;
                        busy_q    <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
